// File: rtl/video_line_writer_if.sv
// Line-RAM write port and line-commit/line-consumed handshake
// between video_line_writer (master) and the output-side reader (slave).
interface video_line_writer_if #(
    parameter int SLOT_BITS = 2
);
    logic [SLOT_BITS+9:0] ram_wraddr;
    logic [23:0]          ram_wrdata;
    logic                 ram_wren;
    logic                 line_commit;
    logic [SLOT_BITS-1:0] commit_slot;
    logic [11:0]          commit_y;
    logic                 line_consumed;

    modport master (
        output ram_wraddr,
        output ram_wrdata,
        output ram_wren,
        output line_commit,
        output commit_slot,
        output commit_y,
        input  line_consumed
    );

    modport slave (
        input  ram_wraddr,
        input  ram_wrdata,
        input  ram_wren,
        input  line_commit,
        input  commit_slot,
        input  commit_y,
        output line_consumed
    );
endinterface

// File: rtl/video_line_writer.sv
// Writes visible lines into a ring of line slots and commits them to the reader.
// Optional macro VIDEO_LINE_WRITER_DROP_COUNT_EN builds the dropped-line counter.
module video_line_writer #(
    parameter int WIDTH_480P  = 720,
    parameter int HEIGHT_480P = 480,
    parameter int WIDTH_240P  = 640,
    parameter int HEIGHT_240P = 240,
    parameter int SLOT_BITS   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           red,
    input  logic [7:0]           green,
    input  logic [7:0]           blue,
    input  logic [11:0]          counterX,
    input  logic [11:0]          counterY,
    input  logic                 add_line,
    input  logic                 line_doubler,
    video_line_writer_if.master  bus,
    output logic                 frame_start,
    output logic [SLOT_BITS:0]   fill_level,
    output logic                 overflow,
    output logic [7:0]           drop_count
);

    localparam logic [11:0] W_480 = 12'(WIDTH_480P);
    localparam logic [11:0] H_480 = 12'(HEIGHT_480P);
    localparam logic [11:0] W_240 = 12'(WIDTH_240P);
    localparam logic [11:0] H_240 = 12'(HEIGHT_240P);
    localparam logic [SLOT_BITS:0] FULL_LVL = {1'b1, {SLOT_BITS{1'b0}}};
    localparam logic [11:0] Y_WRAP = 12'd262;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        COMMIT,
        DROP
    } state_t;

    state_t state;

    logic [23:0] rgb_q;
    logic [11:0] x_q;
    logic [11:0] x_prev;
    logic [11:0] y_q;
    logic        ld_q;
    logic        add_q;

    logic [11:0] w_cur;
    logic [11:0] h_cur;
    logic [11:0] y_line;
    logic [SLOT_BITS-1:0] wr_slot;

    logic                 wren_q;
    logic [SLOT_BITS+9:0] addr_q;
    logic [23:0]          data_q;
    logic                 commit_q;
    logic [SLOT_BITS-1:0] cslot_q;
    logic [11:0]          cy_q;

    logic                 pix_evt;
    logic [11:0]          geo_w;
    logic [11:0]          geo_h;
    logic                 dec;
    logic [SLOT_BITS:0]   fill_after;
    logic                 room;
    logic                 wrap_line;
    logic                 at_end;
    logic                 abort;
    logic                 start;
    logic                 visible;

    assign pix_evt    = (x_q != x_prev);
    assign geo_w      = ld_q ? W_240 : W_480;
    assign geo_h      = ld_q ? H_240 : H_480;
    assign dec        = bus.line_consumed && (fill_level != '0);
    assign fill_after = fill_level - {{SLOT_BITS{1'b0}}, dec};
    assign room       = (fill_after < FULL_LVL);
    // The 263rd line of a 240p frame wraps X early; that is a real line end.
    assign wrap_line  = add_q && (y_line == Y_WRAP);
    assign at_end     = pix_evt && ((x_q == w_cur) || ((x_q == '0) && wrap_line));
    assign abort      = pix_evt && (x_q == '0) && !wrap_line;
    assign start      = pix_evt && (x_q == '0) && (y_q < geo_h);
    assign visible    = (x_q < w_cur) && (y_line < h_cur);

    assign bus.ram_wren    = wren_q;
    assign bus.ram_wraddr  = addr_q;
    assign bus.ram_wrdata  = data_q;
    assign bus.line_commit = commit_q;
    assign bus.commit_slot = cslot_q;
    assign bus.commit_y    = cy_q;

    // Stage 1: register pixel, counters and mode; keep previous X for edge detect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rgb_q  <= '0;
            x_q    <= 12'hFFF;
            x_prev <= 12'hFFF;
            y_q    <= '0;
            ld_q   <= 1'b0;
            add_q  <= 1'b0;
        end else begin
            rgb_q  <= {red, green, blue};
            x_q    <= counterX;
            x_prev <= x_q;
            y_q    <= counterY;
            ld_q   <= line_doubler;
            add_q  <= add_line;
        end
    end

    // Line FSM: start/write/commit/drop with all outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wr_slot     <= '0;
            w_cur       <= '0;
            h_cur       <= '0;
            y_line      <= '0;
            wren_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            commit_q    <= 1'b0;
            cslot_q     <= '0;
            cy_q        <= '0;
            frame_start <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wren_q      <= 1'b0;
            commit_q    <= 1'b0;
            frame_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        w_cur       <= geo_w;
                        h_cur       <= geo_h;
                        y_line      <= y_q;
                        frame_start <= (y_q == '0);
                        if (room) begin
                            state  <= WRITE;
                            wren_q <= 1'b1;
                            addr_q <= {wr_slot, x_q[9:0]};
                            data_q <= rgb_q;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                WRITE: begin
                    if (at_end) begin
                        state    <= COMMIT;
                        commit_q <= 1'b1;
                        cslot_q  <= wr_slot;
                        cy_q     <= y_line;
                    end else if (abort) begin
                        state <= IDLE;
                    end else if (pix_evt && visible) begin
                        wren_q <= 1'b1;
                        addr_q <= {wr_slot, x_q[9:0]};
                        data_q <= rgb_q;
                    end
                end
                COMMIT: begin
                    wr_slot <= wr_slot + 1'b1;
                    state   <= IDLE;
                end
                DROP: begin
                    if (at_end) begin
                        overflow <= 1'b1;
                        state    <= IDLE;
                    end else if (abort) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ring occupancy: +1 when a commit retires, -1 per consume while non-empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fill_level <= '0;
        end else begin
            fill_level <= fill_after
                        + {{SLOT_BITS{1'b0}}, (state == COMMIT)};
        end
    end

`ifdef VIDEO_LINE_WRITER_DROP_COUNT_EN
    logic       drop_end;
    logic [7:0] drop_cnt;

    assign drop_end   = (state == DROP) && at_end;
    assign drop_count = drop_cnt;

    // Saturating count of whole lines dropped because the ring was full.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (drop_end && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_video_line_writer.sv
// Directed bench for video_line_writer: reset, ring fill/drop,
// consume handshake, 240p geometry, frame_start and abandoned lines.
module tb_video_line_writer;

    localparam int SB = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  red = '0;
    logic [7:0]  green = '0;
    logic [7:0]  blue = '0;
    logic [11:0] cx = '0;
    logic [11:0] cy = '0;
    logic        add_line = 1'b0;
    logic        line_doubler = 1'b0;
    logic        consume = 1'b0;
    logic        frame_start;
    logic [SB:0] fill_level;
    logic        overflow;
    logic [7:0]  drop_count;

    video_line_writer_if #(.SLOT_BITS(SB)) bus ();
    assign bus.line_consumed = consume;

    video_line_writer #(.SLOT_BITS(SB)) dut (
        .clock        (clock),
        .reset        (reset),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .counterX     (cx),
        .counterY     (cy),
        .add_line     (add_line),
        .line_doubler (line_doubler),
        .bus          (bus),
        .frame_start  (frame_start),
        .fill_level   (fill_level),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    int          line_tag = 0;
    int          mon_tag = 0;
    logic [11:0] line_y = '0;
    logic [SB-1:0] exp_slot = '0;
    bit          arm = 1'b0;
    int          wr_cnt = 0;
    int          bad_wr = 0;
    int          n_commit = 0;
    int          n_fs = 0;
    logic [SB-1:0] c_slot = '0;
    logic [11:0] c_y = '0;
    int          fs0;

`ifdef VIDEO_LINE_WRITER_DROP_COUNT_EN
    localparam int EXP_DROP = 1;
`else
    localparam int EXP_DROP = 0;
`endif

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int x, input logic [11:0] y);
        logic [11:0] xv;
        xv = 12'(x);
        return {xv[7:0], xv[11:8], y[3:0], xv[7:0] ^ 8'h5A};
    endfunction

    // Scoreboard: every write must land at {slot, index} with the line's data.
    always @(negedge clock) begin
        if (line_tag != mon_tag) begin
            mon_tag  = line_tag;
            wr_cnt   = 0;
            bad_wr   = 0;
            n_commit = 0;
        end
        if (reset) begin
            if (bus.ram_wren) begin
                if (bus.ram_wraddr !== {exp_slot, 10'(wr_cnt)} ||
                    bus.ram_wrdata !== pix(wr_cnt, line_y))
                    bad_wr++;
                wr_cnt++;
            end
            if (bus.line_commit) begin
                n_commit++;
                c_slot = bus.commit_slot;
                c_y    = bus.commit_y;
            end
            if (frame_start) n_fs++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        consume = arm && bus.line_commit;
    endtask

    task automatic pulse_consume();
        consume = 1'b1;
        @(posedge clock);
        #1;
        consume = 1'b0;
    endtask

    task automatic drive_x(input int x, input int y);
        cx = 12'(x);
        {red, green, blue} = pix(x, 12'(y));
        tick();
        tick();
    endtask

    task automatic run_line(input int y, input int xmax, input bit lat);
        line_tag++;
        line_y = 12'(y);
        cy = 12'(y);
        for (int x = 0; x <= xmax; x++) begin
            cx = 12'(x);
            {red, green, blue} = pix(x, 12'(y));
            tick();
            if (lat && x == 0) chk("lat_early", 32'(bus.ram_wren), 0);
            tick();
            if (lat && x == 0) begin
                chk("lat_wren", 32'(bus.ram_wren), 1);
                chk("lat_addr", 32'(bus.ram_wraddr), 32'({exp_slot, 10'd0}));
            end
        end
    endtask

    task automatic line_ok(input string tag, input int nwr, input int ncm,
                           input int slot, input int y, input int fill);
        chk({tag, "_wr"}, 32'(wr_cnt), 32'(nwr));
        chk({tag, "_data"}, 32'(bad_wr), 0);
        chk({tag, "_commit"}, 32'(n_commit), 32'(ncm));
        if (ncm != 0) begin
            chk({tag, "_cslot"}, 32'(c_slot), 32'(slot));
            chk({tag, "_cy"}, 32'(c_y), 32'(y));
        end
        chk({tag, "_fill"}, 32'(fill_level), 32'(fill));
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_wren", 32'(bus.ram_wren), 0);
        chk("rst_commit", 32'(bus.line_commit), 0);
        chk("rst_fill", 32'(fill_level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_drop", 32'(drop_count), 0);
        chk("rst_fs", 32'(frame_start), 0);
        reset = 1'b1;
        tick();
        tick();

        // Reset in the middle of a 480p line while a write is on the bus.
        line_tag++;
        line_y = 12'd3;
        cy = 12'd3;
        exp_slot = '0;
        for (int x = 0; x <= 100; x++) drive_x(x, 3);
        chk("pre_rst_wren", 32'(bus.ram_wren), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_wren", 32'(bus.ram_wren), 0);
        chk("mid_rst_commit", 32'(bus.line_commit), 0);
        chk("mid_rst_fill", 32'(fill_level), 0);
        tick();
        tick();
        reset = 1'b1;
        line_tag++;
        for (int x = 101; x <= 723; x++) drive_x(x, 3);
        chk("post_rst_wr", 32'(wr_cnt), 0);
        chk("post_rst_commit", 32'(n_commit), 0);

        exp_slot = 2'd0;
        run_line(5, 723, 1'b1);
        line_ok("y5", 720, 1, 0, 5, 1);

        // Fresh ring: four lines fill it, the fifth is dropped whole.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_slot = SB'(i);
            run_line(10 + i, 723, 1'b0);
            line_ok("ring", 720, 1, i, 10 + i, i + 1);
        end
        run_line(14, 723, 1'b0);
        line_ok("drop", 0, 0, 0, 0, 4);
        chk("drop_ovf", 32'(overflow), 1);
        chk("drop_cnt", 32'(drop_count), 32'(EXP_DROP));

        // One slot freed: next line wraps to slot 0.
        pulse_consume();
        chk("cons_fill", 32'(fill_level), 3);
        exp_slot = 2'd0;
        run_line(15, 723, 1'b0);
        line_ok("wrap", 720, 1, 0, 15, 4);

        // Consume coinciding with the commit cycle at fill 2.
        pulse_consume();
        pulse_consume();
        chk("fill2", 32'(fill_level), 2);
        exp_slot = 2'd1;
        arm = 1'b1;
        run_line(16, 723, 1'b0);
        arm = 1'b0;
        line_ok("same", 720, 1, 1, 16, 2);
        pulse_consume();
        pulse_consume();
        chk("fill0", 32'(fill_level), 0);
        pulse_consume();
        chk("fill0_hold", 32'(fill_level), 0);

        // 240p geometry: last visible line, invisible line, new frame.
        line_doubler = 1'b1;
        exp_slot = 2'd2;
        run_line(239, 643, 1'b0);
        line_ok("y239", 640, 1, 2, 239, 1);
        run_line(240, 643, 1'b0);
        line_ok("y240", 0, 0, 0, 0, 1);
        fs0 = n_fs;
        exp_slot = 2'd3;
        run_line(0, 643, 1'b0);
        line_ok("y0", 640, 1, 3, 0, 2);
        chk("frame_start", 32'(n_fs - fs0), 1);

        // Short line: X jumps back to 0 early, nothing committed, slot reused.
        exp_slot = 2'd0;
        line_tag++;
        line_y = 12'd1;
        cy = 12'd1;
        for (int x = 0; x <= 50; x++) drive_x(x, 1);
        drive_x(0, 1);
        for (int x = 1; x <= 5; x++) drive_x(x, 1);
        line_ok("abort", 51, 0, 0, 0, 2);
        run_line(2, 643, 1'b0);
        line_ok("reuse", 640, 1, 0, 2, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
